exe_muldiv_unit: RTL and testbench
==================================

# exe_muldiv_unit

Iterative multiply/divide unit in the EXE stage, fed from the ID/EXE pipeline register outputs (operands, opcode, destination address). It accepts one operation at a time and returns a registered result with a write-back address and enable. While an operation is in flight it drives back-pressure (`stall_out`) upstream so IF/ID and the PC hold the issuing instruction. This stall is the return path toward the decode side.

## Interface
- `DSIZE`, 32, operand/result width.
- `ASIZE`, 5, register address width.
- `CSIZE`, 6, iteration counter width; must satisfy 2^CSIZE > DSIZE.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_in`  in  1  ID/EXE holds a mul/div instruction.
- `op_in`  in  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU (quotient), 11 REMU (remainder).
- `a_in`  in  DSIZE  rdata1 from ID/EXE.
- `b_in`  in  DSIZE  rdata2 from ID/EXE.
- `waddr_in`  in  ASIZE  destination register.
- `flush`  in  1  branch/jump taken; abort in-flight op.
- `stall_out`  out  1  hold IF/ID, PC and ID/EXE contents.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle result-valid pulse.
- `result_out`  out  DSIZE  registered result.
- `waddr_out`  out  ASIZE  captured destination.
- `wen_out`  out  1  equals `done`; regfile write enable.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE to RUN: on an edge with `start_in`=1 and `flush`=0 and `b_in`!=0 or op is MUL/MULHU.
  - Latch `a_in`, `b_in`, `op_in` and `waddr_in`.
  - Clear `count`.
- IDLE to DONE: on an edge with `start_in`=1, `flush`=0, op DIVU/REMU and `b_in`=0 (divide-by-zero short cut).
  - DIVU result is all ones.
  - REMU result is `a_in`.
- RUN: one step per edge, `count` increments.
  - Multiply: shift-add into a 2·DSIZE accumulator, one multiplier bit per step, LSB first, unsigned.
  - Divide: restoring, one quotient bit per step, MSB first, with a DSIZE+1-bit partial remainder. Unsigned.
- RUN to DONE: on the edge completing step DSIZE (`count`=DSIZE-1).
  - `result_out` loads the low or high product word (MUL/MULHU), or the quotient or remainder (DIVU/REMU).
- DONE to IDLE: unconditionally on the next edge.
  - `start_in` is ignored in DONE; it still refers to the finishing instruction.
- `flush`=1 at an edge in RUN: go to IDLE. No `done`, `result_out` unchanged.
- `flush`=1 at an edge in DONE: the write still completes. That instruction is older than the flushing branch.
- `flush`=1 in IDLE: `start_in` is ignored.
- Priority: `rst` > `flush` > normal transitions.
- `stall_out` is combinational: (IDLE & `start_in` & ~`flush`) | RUN. It is 0 in DONE, so the pipeline advances on the DONE-to-IDLE edge.
- `result_out` and `waddr_out` hold their last values between operations.

## Timing
- Reset (async, immediate) sets:
  - state IDLE, `count`=0;
  - `result_out`=0, `waddr_out`=0, `done`=0, `wen_out`=0, `busy`=0;
  - `stall_out`=0 provided `start_in`=0;
  - internal accumulators 0.
- Normal op, start sampled at edge T0:
  - RUN spans edges T1..T_DSIZE (DSIZE steps; DONE is entered on T_DSIZE).
  - `done`=`wen_out`=1 between T_DSIZE and T_DSIZE+1.
  - Latency from start edge to `done` is DSIZE cycles. Stall is high DSIZE+1 cycles, counting the cycle before T0.
- Divide-by-zero: DONE is entered at T0. `done` is high in the cycle after T0. Stall is 1 cycle.
- Back-to-back ops: a new start can be sampled at the DONE-to-IDLE edge plus one. This gives at least one idle cycle between ops.
- Reset asserted mid-RUN: immediate return to IDLE. No `done` pulse follows reset release.
- Counter never wraps: `count` ≤ DSIZE-1 in RUN, and is cleared in IDLE.

## Test plan
- MUL, a=7, b=6 → `stall_out` high 33 cycles, `done` 32 cycles after the start edge, `result_out`=42, `waddr_out`=captured address, `wen_out` one cycle.
- MULHU and MUL, a=b=0xFFFFFFFF → MULHU result 0xFFFFFFFE; MUL result 0x00000001.
- DIVU 100/7 → 14. REMU 100/7 → 2. Also DIVU 0x80000000/1 → 0x80000000 (MSB handling).
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both with `done` one cycle after the start edge and no RUN state.
- `flush` on the 10th RUN cycle of a MUL → no `done`, `busy` drops; a following DIVU 9/3 returns 3 correctly.
- Assert `rst` asynchronously (between edges) mid-RUN → all outputs go to reset values without a clock edge. After release with `start_in`=0, no spurious `done`.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// ----------------------------------------------------------------------------
// exe_muldiv_unit : iterative unsigned multiply/divide for the EXE stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exe_muldiv_unit #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int CSIZE = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [DSIZE-1:0] a_in,
  input  logic [DSIZE-1:0] b_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             flush,
  output logic             stall_out,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] result_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out
);

  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_RUN  = 2'd1;
  localparam logic [1:0]       S_DONE = 2'd2;
  localparam logic [CSIZE-1:0] C_LAST = CSIZE'(DSIZE - 1);

  logic [1:0]         state_q, state_d;
  logic [CSIZE-1:0]   count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic [DSIZE-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [ASIZE-1:0]   waddr_q, waddr_d;
  logic [2*DSIZE-1:0] acc_q, acc_d;
  logic [DSIZE:0]     rem_q, rem_d;

  logic               start_ok, div0, last;
  logic [DSIZE:0]     mul_sum, div_shift, div_rem;
  logic [2*DSIZE-1:0] mul_next;
  logic [DSIZE-1:0]   div_quo;
  logic               div_ge;

  assign start_ok = start_in & ~flush;
  assign div0     = op_in[1] & (b_in == '0);
  assign last     = (count_q == C_LAST);

  // Multiply: acc = {high partial, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*DSIZE-1:DSIZE]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[DSIZE-1:1]};

  // Divide: dividend bits leave a_q at the top while quotient bits enter at the bottom.
  assign div_shift = {rem_q[DSIZE-1:0], a_q[DSIZE-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
  assign div_quo   = {a_q[DSIZE-2:0], div_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = div0 ? S_DONE : S_RUN;
      S_RUN:   if (flush) state_d = S_IDLE;
               else if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_out = ((state_q == S_IDLE) & start_ok) | (state_q == S_RUN);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    wen_out   = done;
  end

  always_comb begin
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    waddr_d  = waddr_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (state_q == S_IDLE) begin
      count_d = '0;
      if (start_ok) begin
        op_d    = op_in;
        a_d     = a_in;
        b_d     = b_in;
        waddr_d = waddr_in;
        acc_d   = {{DSIZE{1'b0}}, a_in};
        rem_d   = '0;
        if (div0) result_d = op_in[0] ? a_in : '1;
      end
    end else if (state_q == S_RUN && !flush) begin
      count_d = count_q + CSIZE'(1);
      if (op_q[1]) begin
        a_d   = div_quo;
        rem_d = div_rem;
      end else begin
        acc_d = mul_next;
      end
      if (last) begin
        case (op_q)
          2'b00:   result_d = mul_next[DSIZE-1:0];
          2'b01:   result_d = mul_next[2*DSIZE-1:DSIZE];
          2'b10:   result_d = div_quo;
          default: result_d = div_rem[DSIZE-1:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      waddr_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      waddr_q  <= waddr_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign result_out = result_q;
  assign waddr_out  = waddr_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_exe_muldiv_unit : directed scoreboard bench for exe_muldiv_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exe_muldiv_unit;

  localparam int DSIZE = 32;
  localparam int ASIZE = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_in;
  logic [1:0]       op_in;
  logic [DSIZE-1:0] a_in, b_in;
  logic [ASIZE-1:0] waddr_in;
  logic             flush;
  logic             stall_out, busy, done, wen_out;
  logic [DSIZE-1:0] result_out;
  logic [ASIZE-1:0] waddr_out;

  int errors = 0;
  int checks = 0;
  logic [DSIZE-1:0] exp_res_q[$];
  logic [ASIZE-1:0] exp_wa_q[$];

  exe_muldiv_unit #(.DSIZE(DSIZE), .ASIZE(ASIZE), .CSIZE(6)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .waddr_in(waddr_in), .flush(flush),
    .stall_out(stall_out), .busy(busy), .done(done),
    .result_out(result_out), .waddr_out(waddr_out), .wen_out(wen_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, track stall/latency, and check the write-back against the scoreboard.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input int exp_lat);
    int lat, st;
    op_in = op; a_in = a; b_in = b; waddr_in = wa; start_in = 1'b1;
    exp_res_q.push_back(model(op, a, b));
    exp_wa_q.push_back(wa);
    #1;
    st = stall_out ? 1 : 0;
    tick();
    start_in = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (stall_out) st++;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " stall_cycles"}, st, exp_lat + 1);
    check({tag, " wen"}, {31'b0, wen_out}, 32'd1);
    check({tag, " stall_in_done"}, {31'b0, stall_out}, 32'd0);
    check({tag, " result"}, result_out, exp_res_q.pop_front());
    check({tag, " waddr"}, {27'b0, waddr_out}, {27'b0, exp_wa_q.pop_front()});
    tick();
    check({tag, " done_pulse_1cyc"}, {31'b0, done}, 32'd0);
    check({tag, " idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int dcount;
    logic [31:0] held;
    rst = 1'b1; start_in = 1'b0; op_in = '0; a_in = '0; b_in = '0;
    waddr_in = '0; flush = 1'b0;
    #12;
    check("reset result", result_out, 32'd0);
    check("reset waddr", {27'b0, waddr_out}, 32'd0);
    check("reset done/wen/busy/stall", {28'b0, done, wen_out, busy, stall_out}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("MUL 7*6", 2'b00, 32'd7, 32'd6, 5'd9, 32);
    check("MUL 7*6 literal", result_out, 32'd42);
    run_op("MULHU ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32);
    check("MULHU literal", result_out, 32'hFFFF_FFFE);
    run_op("MUL ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32);
    check("MUL ones literal", result_out, 32'h0000_0001);
    run_op("DIVU 100/7", 2'b10, 32'd100, 32'd7, 5'd10, 32);
    check("DIVU literal", result_out, 32'd14);
    run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 5'd11, 32);
    check("REMU literal", result_out, 32'd2);
    run_op("DIVU msb/1", 2'b10, 32'h8000_0000, 32'd1, 5'd12, 32);
    run_op("MULHU mixed", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 32);
    run_op("REMU big", 2'b11, 32'hDEAD_BEEF, 32'h0001_0003, 5'd14, 32);
    run_op("DIVU 5/0", 2'b10, 32'd5, 32'd0, 5'd15, 0);
    run_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 5'd16, 0);

    // Flush during the 10th RUN cycle of a MUL.
    held = result_out;
    op_in = 2'b00; a_in = 32'd123; b_in = 32'd456; waddr_in = 5'd20; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (9) tick();
    check("flush pre busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush stall", {31'b0, stall_out}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      tick();
    end
    check("flush no done", dcount, 32'd0);
    check("flush result held", result_out, held);
    run_op("DIVU 9/3", 2'b10, 32'd9, 32'd3, 5'd21, 32);

    // Asynchronous reset mid-RUN.
    op_in = 2'b00; a_in = 32'd77; b_in = 32'd88; waddr_in = 5'd22; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async rst result", result_out, 32'd0);
    check("async rst waddr", {27'b0, waddr_out}, 32'd0);
    check("async rst done/wen/busy/stall", {28'b0, done, wen_out, busy, stall_out}, 32'd0);
    #1;
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    check("post rst no activity", dcount, 32'd0);
    check("scoreboard empty", exp_res_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
